// File: rtl/aes_block_packer.sv
`default_nettype none
// ============================================================================
// Module  : aes_block_packer
// Brief   : Pops bytes from a byte FIFO and packs them MSB-first into AES
//           blocks with valid/ready output. Optional PACKER_PKCS7_EN selects
//           PKCS#7 padding on flush (otherwise zero padding).
// Revision: 1.0
// ============================================================================
module aes_block_packer #(
    parameter int WIDTH      = 8,
    parameter int BLOCK_BITS = 128
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              fifo_empty,
    output logic                              fifo_rd_en,
    input  logic [WIDTH-1:0]                  fifo_dout,
    input  logic                              flush,
    output logic                              blk_valid,
    input  logic                              blk_ready,
    output logic [BLOCK_BITS-1:0]             blk_data,
    output logic [$clog2(BLOCK_BITS/WIDTH):0] byte_cnt
);
    localparam int BYTES = BLOCK_BITS / WIDTH;
    localparam int CW    = $clog2(BYTES) + 1;
    localparam logic [CW-1:0] BYTES_C = CW'(BYTES);
    localparam logic [CW-1:0] LAST_C  = CW'(BYTES - 1);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]            state;
    logic [0:0]            state_next;
    logic [CW-1:0]         issued;
    logic                  rd_pending;
    logic                  flush_req;
    logic                  last_capture;
    logic                  flush_done;
    logic                  flush_emit;
    logic                  handshake;
    logic [WIDTH-1:0]      pad_byte;
    logic [BLOCK_BITS-1:0] data_cap;
    logic [BLOCK_BITS-1:0] data_pad;

    assign last_capture = rd_pending && (byte_cnt == LAST_C);
    // Flush waits for any in-flight byte so it lands before the padding.
    assign flush_done   = (state == ST_FILL) && flush_req && !rd_pending;
    assign handshake    = (state == ST_HOLD) && blk_ready;

`ifdef PACKER_PKCS7_EN
    assign flush_emit = flush_done;
    assign pad_byte   = WIDTH'(BYTES_C - byte_cnt);
`else
    assign flush_emit = flush_done && (byte_cnt != '0);
    assign pad_byte   = '0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_FILL: begin
                if (last_capture || flush_emit) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (blk_ready) begin
                    state_next = ST_FILL;
                end
            end
            default: state_next = ST_FILL;
        endcase
    end

    always_comb begin
        fifo_rd_en = 1'b0;
        blk_valid  = 1'b0;
        case (state)
            ST_FILL: fifo_rd_en = !fifo_empty && (issued < BYTES_C) && !flush_req;
            ST_HOLD: blk_valid  = 1'b1;
            default: ;
        endcase
    end

    // Slot 0 is the MSB byte of the block.
    always_comb begin
        data_cap = blk_data;
        data_pad = blk_data;
        for (int i = 0; i < BYTES; i++) begin
            if (CW'(i) == byte_cnt) begin
                data_cap[BLOCK_BITS-1-i*WIDTH -: WIDTH] = fifo_dout;
            end
            if (CW'(i) >= byte_cnt) begin
                data_pad[BLOCK_BITS-1-i*WIDTH -: WIDTH] = pad_byte;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            issued     <= '0;
            rd_pending <= 1'b0;
            flush_req  <= 1'b0;
            byte_cnt   <= '0;
            blk_data   <= '0;
        end else begin
            rd_pending <= fifo_rd_en;
            if (handshake) begin
                issued   <= '0;
                byte_cnt <= '0;
                blk_data <= '0;
            end else begin
                if (fifo_rd_en) begin
                    issued <= issued + CW'(1);
                end
                if (rd_pending) begin
                    blk_data <= data_cap;
                    byte_cnt <= byte_cnt + CW'(1);
                end else if (flush_emit) begin
                    blk_data <= data_pad;
                end
            end
            // A flush racing the final byte is absorbed by the full block.
            if ((state == ST_HOLD) || last_capture || flush_done) begin
                flush_req <= 1'b0;
            end else if (flush) begin
                flush_req <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_block_packer.sv
`default_nettype none
// ============================================================================
// Module  : tb_aes_block_packer
// Brief   : Self-checking bench for aes_block_packer with a FIFO model and a
//           byte-stream block reference model. Honours PACKER_PKCS7_EN.
// Revision: 1.0
// ============================================================================
module tb_aes_block_packer;
    localparam int WIDTH      = 8;
    localparam int BLOCK_BITS = 128;

    logic         clk        = 1'b0;
    logic         rstn       = 1'b0;
    logic         fifo_empty = 1'b1;
    logic         fifo_rd_en;
    logic [7:0]   fifo_dout  = 8'h00;
    logic         flush      = 1'b0;
    logic         blk_valid;
    logic         blk_ready  = 1'b0;
    logic [127:0] blk_data;
    logic [4:0]   byte_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int n_reads  = 0;
    int base;

    logic [7:0]   fifo_q[$];
    logic [7:0]   mbuf[$];
    logic [127:0] exp_q[$];
    bit           rand_ready = 1'b0;
    bit           pend       = 1'b0;
    logic [7:0]   held       = 8'h00;

    aes_block_packer #(.WIDTH(WIDTH), .BLOCK_BITS(BLOCK_BITS)) dut (
        .clk(clk), .rstn(rstn), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_dout(fifo_dout), .flush(flush), .blk_valid(blk_valid),
        .blk_ready(blk_ready), .blk_data(blk_data), .byte_cnt(byte_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: bytes in arrival order, 16 per block, flush pads the tail.
    function automatic logic [127:0] pack_buf(input logic [7:0] pad);
        logic [127:0] b = '0;
        for (int i = 0; i < 16; i++) begin
            b[127-8*i -: 8] = (i < mbuf.size()) ? mbuf[i] : pad;
        end
        return b;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        mbuf.push_back(b);
        if (mbuf.size() == 16) begin
            exp_q.push_back(pack_buf(8'h00));
            mbuf.delete();
        end
    endtask

    // A block awaiting acceptance means the packer ignores the flush.
    task automatic do_flush();
        if (exp_q.size() == 0 && mbuf.size() != 0) begin
`ifdef PACKER_PKCS7_EN
            exp_q.push_back(pack_buf(8'(16 - mbuf.size())));
`else
            exp_q.push_back(pack_buf(8'h00));
`endif
            mbuf.delete();
        end
`ifdef PACKER_PKCS7_EN
        else if (exp_q.size() == 0) begin
            exp_q.push_back({16{8'h10}});
        end
`endif
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drained(input string tag);
        int k = 0;
        while (fifo_q.size() != 0 && k < 400) begin @(negedge clk); k++; end
        chk(tag, fifo_q.size() == 0, 1'b1);
    endtask

    task automatic wait_blocks(input string tag);
        int k = 0;
        while (exp_q.size() != 0 && k < 600) begin @(negedge clk); k++; end
        chk(tag, exp_q.size() == 0, 1'b1);
    endtask

    task automatic wait_reads(input int n, input string tag);
        int k = 0;
        while (n_reads < n && k < 200) begin @(negedge clk); #4; k++; end
        chk(tag, n_reads >= n, 1'b1);
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!blk_valid && k < 200) begin @(negedge clk); #4; k++; end
        chk(tag, blk_valid, 1'b1);
    endtask

    task automatic wait_cnt(input int n, input string tag);
        int k = 0;
        while (byte_cnt != 5'(n) && k < 200) begin @(negedge clk); #4; k++; end
        chk(tag, byte_cnt, 5'(n));
    endtask

    // FIFO model: a read seen in one cycle returns its byte the next cycle.
    initial forever begin
        @(negedge clk);
        fifo_dout  = pend ? held : 8'h00;
        fifo_empty = (fifo_q.size() == 0);
        if (rand_ready) blk_ready = 1'($urandom_range(0, 1));
        #2;
        if (!rstn) begin
            pend = 1'b0;
        end else if (fifo_rd_en) begin
            chk("no_overread", fifo_q.size() == 0, 1'b0);
            held = (fifo_q.size() != 0) ? fifo_q.pop_front() : 8'h00;
            pend = 1'b1;
            n_reads++;
        end else begin
            pend = 1'b0;
        end
    end

    // Output monitor: handshakes, hold stability, no reads while holding.
    initial begin
        logic [127:0] prev_data = '0;
        bit prev_valid = 1'b0;
        bit prev_hs    = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (!rstn) begin
                prev_valid = 1'b0;
                prev_hs    = 1'b0;
                continue;
            end
            if (prev_hs) begin
                chk("post_hs_valid", blk_valid, 1'b0);
                chk("post_hs_cnt", byte_cnt, 5'd0);
                chk("post_hs_data", blk_data, '0);
            end
            if (blk_valid) chk("rd_in_hold", fifo_rd_en, 1'b0);
            if (blk_valid && prev_valid && !prev_hs) chk("hold_stable", blk_data, prev_data);
            prev_hs = 1'b0;
            if (blk_valid && blk_ready) begin
                chk("unexpected_blk", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) chk("blk_data", blk_data, exp_q.pop_front());
                prev_hs = 1'b1;
            end
            prev_valid = blk_valid;
            prev_data  = blk_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #4;
        chk("rst_valid", blk_valid, 1'b0);
        chk("rst_data", blk_data, '0);
        chk("rst_cnt", byte_cnt, 5'd0);
        chk("rst_rd", fifo_rd_en, 1'b0);
        @(negedge clk);
        #1 rstn = 1'b1;

        // Full block 00..0F with two-cycle latency from the last read.
        @(negedge clk);
        blk_ready = 1'b1;
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        wait_reads(16, "t1_reads_to");
        chk("t1_reads", n_reads, 16);
        @(negedge clk); #4;
        chk("t1_lat", blk_valid, 1'b0);
        @(negedge clk); #4;
        chk("t1_valid", blk_valid, 1'b1);
        chk("t1_data", blk_data, 128'h000102030405060708090A0B0C0D0E0F);
        @(negedge clk); #4;
        chk("t1_one_cycle", blk_valid, 1'b0);
        chk("t1_cnt", byte_cnt, 5'd0);

        // Two blocks with back-pressure on the first.
        @(negedge clk);
        blk_ready = 1'b0;
        for (int i = 0; i < 32; i++) push_byte(8'(i));
        wait_valid("t2_valid");
        cycles(10);
        chk("t2_reads_held", n_reads, 32);
        blk_ready = 1'b1;
        wait_blocks("t2_done");
        chk("t2_reads", n_reads, 48);

        // Partial block closed by flush.
        push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC);
        wait_drained("t3_drain");
        cycles(3);
        do_flush();
        wait_blocks("t3_done");

        // Flush with the last byte still in flight, then back-pressure.
        for (int i = 0; i < 3; i++) push_byte(8'($urandom));
        wait_drained("t4_drain");
        blk_ready = 1'b0;
        base = n_reads;
        do_flush();
        push_byte(8'($urandom)); push_byte(8'($urandom));
        cycles(8);
        chk("t4_no_rd", n_reads, base);
        blk_ready = 1'b1;
        wait_blocks("t4_done");
        wait_drained("t4_drain2");
        cycles(3);
        do_flush();
        wait_blocks("t4_done2");

        // Flush on an empty block.
        cycles(2);
        do_flush();
        cycles(6);
        wait_blocks("t5_done");
        chk("t5_cnt", byte_cnt, 5'd0);

        // Flush while holding, then flush racing the completing read.
        blk_ready = 1'b0;
        for (int i = 0; i < 16; i++) push_byte(8'($urandom));
        wait_valid("t6_valid");
        @(negedge clk);
        do_flush();
        cycles(3);
        blk_ready = 1'b1;
        wait_blocks("t6_done");
        base = n_reads;
        @(negedge clk);
        for (int i = 0; i < 16; i++) push_byte(8'($urandom));
        wait_reads(base + 15, "t6_reads15");
        @(negedge clk);
        do_flush();
        cycles(4);
        wait_blocks("t6_done2");
        cycles(4);

        // Asynchronous reset with a partial block.
        for (int i = 0; i < 7; i++) push_byte(8'($urandom));
        wait_cnt(7, "t7_cnt7");
        @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("t7_rst_valid", blk_valid, 1'b0);
        chk("t7_rst_data", blk_data, '0);
        chk("t7_rst_cnt", byte_cnt, 5'd0);
        chk("t7_rst_rd", fifo_rd_en, 1'b0);
        mbuf.delete();
        @(negedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) push_byte(8'($urandom));
        wait_blocks("t7_done");

        // Random bursts, gaps, ready toggling and flushes.
        rand_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 40);
            for (int j = 0; j < n; j++) begin
                push_byte(8'($urandom));
                if ($urandom_range(0, 2) == 0) @(negedge clk);
            end
            if ($urandom_range(0, 1) == 1) begin
                wait_drained("rnd_drain");
                cycles($urandom_range(0, 3));
                do_flush();
            end
        end
        rand_ready = 1'b0;
        @(negedge clk);
        blk_ready = 1'b1;
        wait_drained("final_drain");
        if (mbuf.size() != 0) begin
            cycles(2);
            do_flush();
        end
        wait_blocks("final_done");
        cycles(5);
        chk("final_cnt", byte_cnt, 5'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
